mips_alu: RTL and testbench

//  32-bit combinational integer ALU for the MIPS datapath, instantiated in the EXE stage.
//  - Computes alu_result from operands a, b and a 4-bit opcode (control).
//  - Provides zero/negative/overflow flags and a sticky signed-overflow status register.
//  - EXE stage consumes alu_result in the same cycle (default build, no latency).

---
 rtl/mips_alu_pkg.sv | 26 ++
 rtl/mips_alu_shifter.sv | 32 +++
 rtl/mips_alu.sv | 125 ++++++++++++
 tb/tb_mips_alu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared opcode encoding and width for the MIPS EXE-stage ALU.
package mips_alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_NOR  = 4'b1100
    } alu_op_e;

    // SUB, SLT and SLTU all run the adder as a - b.
    function automatic logic uses_subtract(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/mips_alu_shifter.sv
// 32-bit logarithmic barrel shifter: dir=0 left, dir=1 right; arith selects sign fill on right shifts.
module mips_alu_shifter
    import mips_alu_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [4:0]        shamt,
    input  logic              dir,
    input  logic              arith,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] ONES = '1;

    logic              fill;
    logic [DATA_W-1:0] stage;

    always_comb begin
        fill  = arith & data[DATA_W-1];
        stage = data;
        for (int i = 0; i < 5; i++) begin
            if (shamt[i]) begin
                if (dir) begin
                    stage = (stage >> (1 << i)) | (fill ? ~(ONES >> (1 << i)) : '0);
                end else begin
                    stage = stage << (1 << i);
                end
            end
        end
        result = stage;
    end

endmodule

// File: rtl/mips_alu.sv
// MIPS EXE-stage ALU with flags and sticky signed-overflow status.
// Define ALU_OUT_REG_EN to register the result and flags (1-cycle latency).
module mips_alu
    import mips_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        control,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              negative,
    output logic              overflow,
    output logic              illegal_op,
    output logic              ovf_sticky
);

    logic              sub_mode;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum_full;
    logic [DATA_W-1:0] sum;
    logic              carry_out;
    logic              add_ovf;
    logic              sub_ovf;
    logic              slt_bit;
    logic              sltu_bit;

    logic              shift_dir;
    logic              shift_arith;
    logic [DATA_W-1:0] shift_res;

    logic [DATA_W-1:0] result_c;
    logic              overflow_c;
    logic              illegal_c;
    logic              zero_c;
    logic              negative_c;

    // One carry chain: subtraction is a + ~b + 1.
    assign sub_mode  = uses_subtract(control);
    assign b_eff     = sub_mode ? ~b : b;
    assign sum_full  = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_mode};
    assign sum       = sum_full[DATA_W-1:0];
    assign carry_out = sum_full[DATA_W];

    assign add_ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    assign sub_ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    // Signed less-than is the true sign of a-b, corrected for overflow; unsigned is borrow.
    assign slt_bit  = sum[DATA_W-1] ^ sub_ovf;
    assign sltu_bit = ~carry_out;

    assign shift_dir   = (control != ALU_SLL);
    assign shift_arith = (control == ALU_SRA);

    mips_alu_shifter u_shifter (
        .data   (a),
        .shamt  (b[4:0]),
        .dir    (shift_dir),
        .arith  (shift_arith),
        .result (shift_res)
    );

    always_comb begin
        result_c   = '0;
        overflow_c = 1'b0;
        illegal_c  = 1'b0;
        case (alu_op_e'(control))
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_ADD: begin
                result_c   = sum;
                overflow_c = add_ovf;
            end
            ALU_XOR:  result_c = a ^ b;
            ALU_SLL:  result_c = shift_res;
            ALU_SRL:  result_c = shift_res;
            ALU_SRA:  result_c = shift_res;
            ALU_SUB: begin
                result_c   = sum;
                overflow_c = sub_ovf;
            end
            ALU_SLT:  result_c = {{(DATA_W-1){1'b0}}, slt_bit};
            ALU_SLTU: result_c = {{(DATA_W-1){1'b0}}, sltu_bit};
            ALU_LUI:  result_c = {b[15:0], 16'h0000};
            ALU_NOR:  result_c = ~(a | b);
            default:  illegal_c = 1'b1;
        endcase
        zero_c     = (result_c == '0);
        negative_c = result_c[DATA_W-1];
    end

    // Sticky flag always watches the unregistered overflow so it never lags the op.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= ovf_sticky | overflow_c;
        end
    end

`ifdef ALU_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            alu_result <= '0;
            zero       <= 1'b1;
            negative   <= 1'b0;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            alu_result <= result_c;
            zero       <= zero_c;
            negative   <= negative_c;
            overflow   <= overflow_c;
            illegal_op <= illegal_c;
        end
    end
`else
    assign alu_result = result_c;
    assign zero       = zero_c;
    assign negative   = negative_c;
    assign overflow   = overflow_c;
    assign illegal_op = illegal_c;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector bench for mips_alu; works for both the combinational and ALU_OUT_REG_EN builds.
module tb_mips_alu;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  control = 4'b0000;
    logic [31:0] alu_result;
    logic        zero;
    logic        negative;
    logic        overflow;
    logic        illegal_op;
    logic        ovf_sticky;

    int n_chk  = 0;
    int n_fail = 0;

    mips_alu dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .a          (a),
        .b          (b),
        .control    (control),
        .alu_result (alu_result),
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow),
        .illegal_op (illegal_op),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive at a falling edge and sample at the next one, so a posedge lies in between.
    task automatic apply(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        control = op;
        a       = va;
        b       = vb;
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{"sub_eq",     4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0},
            '{"sub_ovf",    4'b0110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1, 1'b0},
            '{"add_wrap",   4'b0010, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
            '{"add_nofl",   4'b0010, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0},
            '{"slt_neg",    4'b0111, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
            '{"sltu_neg",   4'b1001, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
            '{"slt_ovf",    4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
            '{"sltu_lt",    4'b1001, 32'h00000001, 32'hffffffff, 32'h00000001, 1'b0, 1'b0},
            '{"slt_ge",     4'b0111, 32'h00000001, 32'hffffffff, 32'h00000000, 1'b0, 1'b0},
            '{"sra",        4'b1000, 32'h80000000, 32'h00000024, 32'hf8000000, 1'b0, 1'b0},
            '{"srl",        4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0},
            '{"sll_hi_b",   4'b0100, 32'h00000001, 32'hffffffe1, 32'h00000002, 1'b0, 1'b0},
            '{"sll_31",     4'b0100, 32'h00000001, 32'h0000001f, 32'h80000000, 1'b0, 1'b0},
            '{"sra_pos31",  4'b1000, 32'h7fffffff, 32'h0000001f, 32'h00000000, 1'b0, 1'b0},
            '{"sra_neg31",  4'b1000, 32'h80000000, 32'h0000001f, 32'hffffffff, 1'b0, 1'b0},
            '{"and",        4'b0000, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0, 1'b0},
            '{"or",         4'b0001, 32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0, 1'b0},
            '{"xor",        4'b0011, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 1'b0, 1'b0},
            '{"nor",        4'b1100, 32'hf0f0f0f0, 32'hff00ff00, 32'h000f000f, 1'b0, 1'b0},
            '{"lui",        4'b1010, 32'hffffffff, 32'h00001234, 32'h12340000, 1'b0, 1'b0},
            '{"ill_1011",   4'b1011, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0, 1'b1},
            '{"ill_1101",   4'b1101, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0, 1'b1},
            '{"ill_1110",   4'b1110, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0, 1'b1},
            '{"ill_1111",   4'b1111, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0, 1'b1}
        };

        // Reset state: inputs idle as AND 0,0 so both builds show result 0, zero=1.
        #12;
        chk("rst_sticky", {31'b0, ovf_sticky}, 32'h0);
        chk("rst_result", alu_result, 32'h0);
        chk("rst_zero",   {31'b0, zero}, 32'h1);
        @(negedge clk);
        rst_b = 1'b1;

        apply(4'b0010, 32'h7fffffff, 32'h00000001);
        chk("add_ovf_res",  alu_result, 32'h80000000);
        chk("add_ovf_ovf",  {31'b0, overflow}, 32'h1);
        chk("add_ovf_neg",  {31'b0, negative}, 32'h1);
        chk("add_ovf_stk",  {31'b0, ovf_sticky}, 32'h1);

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].va, vecs[i].vb);
            chk({vecs[i].name, "_res"}, alu_result, vecs[i].res);
            chk({vecs[i].name, "_zero"}, {31'b0, zero}, {31'b0, vecs[i].res == 32'h0});
            chk({vecs[i].name, "_neg"}, {31'b0, negative}, {31'b0, vecs[i].res[31]});
            chk({vecs[i].name, "_ovf"}, {31'b0, overflow}, {31'b0, vecs[i].ovf});
            chk({vecs[i].name, "_ill"}, {31'b0, illegal_op}, {31'b0, vecs[i].ill});
        end
        chk("stk_held", {31'b0, ovf_sticky}, 32'h1);

        // Mid-run reset: sticky clears immediately.
        apply(4'b0010, 32'h00000002, 32'h00000003);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_stk", {31'b0, ovf_sticky}, 32'h0);
`ifdef ALU_OUT_REG_EN
        chk("mid_rst_res",  alu_result, 32'h0);
        chk("mid_rst_zero", {31'b0, zero}, 32'h1);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("lat_before", alu_result, 32'h0);
        @(posedge clk);
        #1;
        chk("lat_after",  alu_result, 32'h5);
        chk("lat_zero",   {31'b0, zero}, 32'h0);
`else
        chk("mid_rst_res",  alu_result, 32'h5);
        chk("mid_rst_zero", {31'b0, zero}, 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
`endif
        @(negedge clk);
        chk("post_rst_stk", {31'b0, ovf_sticky}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
